// File: rtl/sdram_rd_pkg.sv
// Shared types and constants for the SDRAM block-read feeder.
package sdram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  localparam int BLEN_W        = 5;
  localparam int INFLIGHT_W    = 7;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_MARGIN    = 4;

  // Length of the next burst: the smaller of the remaining words and the burst cap.
  function automatic logic [BLEN_W-1:0] burst_len(input logic [31:0] remaining,
                                                  input logic [31:0] max_len);
    if (remaining < max_len) begin
      return remaining[BLEN_W-1:0];
    end
    return max_len[BLEN_W-1:0];
  endfunction

endpackage

// File: rtl/sdram_read_credit.sv
// In-flight word counter and FIFO credit check for the SDRAM read feeder.
module sdram_read_credit
  import sdram_rd_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int MARGIN     = DEF_MARGIN
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  issue,
  input  logic [BLEN_W-1:0]     issue_len,
  input  logic [BLEN_W-1:0]     query_len,
  input  logic                  rd_valid,
  input  logic [5:0]            wrusedw,
  input  logic                  wrfull,
  output logic                  credit_ok,
  output logic [INFLIGHT_W-1:0] inflight,
  output logic                  inflight_next_zero
);

  localparam logic [7:0] LIMIT = 8'(FIFO_DEPTH - MARGIN);

  logic [INFLIGHT_W-1:0] inflight_q, inflight_d, base;
  logic [7:0]            need;

  // A word returning while nothing is outstanding is stale and must not underflow the count.
  // Credit is judged against the count including a burst handed off this cycle, without
  // crediting back a word returning this cycle, so the check stays conservative.
  always_comb begin
    base       = inflight_q + (issue ? INFLIGHT_W'(issue_len) : '0);
    inflight_d = base;
    if (rd_valid && (inflight_q != '0)) begin
      inflight_d = base - INFLIGHT_W'(1);
    end
    need      = 8'(wrusedw) + 8'(base) + 8'(query_len);
    credit_ok = !wrfull && (need <= LIMIT);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign inflight           = inflight_q;
  assign inflight_next_zero = (inflight_d == '0);

endmodule

// File: rtl/sdram_read_burst.sv
// Splits block-read requests into credit-limited SDRAM bursts and forwards returned words to the FIFO.
module sdram_read_burst
  import sdram_rd_pkg::*;
#(
  parameter int ADDR_W     = 25,
  parameter int LEN_W      = 16,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int FIFO_DEPTH = 64,
  parameter int MARGIN     = DEF_MARGIN
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sdr_cmd_valid,
  input  logic              sdr_cmd_ready,
  output logic [ADDR_W-1:0] sdr_cmd_addr,
  output logic [4:0]        sdr_cmd_len,
  input  logic              sdr_rd_valid,
  input  logic [15:0]       sdr_rd_data,
  output logic              fifo_wrreq,
  output logic [15:0]       fifo_data,
  input  logic [5:0]        fifo_wrusedw,
  input  logic              fifo_wrfull
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d, addr_after;
  logic [ADDR_W-1:0]     cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d, rem_after;
  logic [BLEN_W-1:0]     cmd_len_q, cmd_len_d, query_len;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  wrreq_q, wrreq_d;
  logic [15:0]           data_q, data_d;
  logic                  cmd_hs;
  logic                  credit_ok;
  logic                  drain_empty;
  logic [INFLIGHT_W-1:0] inflight;

  // Address and count as they will be once any handshake this cycle completes.
  assign cmd_hs     = cmd_valid_q && sdr_cmd_ready;
  assign rem_after  = cmd_hs ? (remaining_q - LEN_W'(cmd_len_q)) : remaining_q;
  assign addr_after = cmd_hs ? (addr_q + ADDR_W'(cmd_len_q)) : addr_q;
  assign query_len  = burst_len(32'(rem_after), 32'(BURST_LEN));

  sdram_read_credit #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .MARGIN    (MARGIN)
  ) u_credit (
    .clk               (clk),
    .aclr              (aclr),
    .issue             (cmd_hs),
    .issue_len         (cmd_len_q),
    .query_len         (query_len),
    .rd_valid          (sdr_rd_valid),
    .wrusedw           (fifo_wrusedw),
    .wrfull            (fifo_wrfull),
    .credit_ok         (credit_ok),
    .inflight          (inflight),
    .inflight_next_zero(drain_empty)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    err_d       = err_q;
    done_d      = (state_q == DONE);
    wrreq_d     = sdr_rd_valid;
    data_d      = sdr_rd_data;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr;
          remaining_d = req_len;
          err_d       = 1'b0;
          state_d     = (req_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        addr_d      = addr_after;
        remaining_d = rem_after;
        // A presented command is frozen until accepted; credit is only consulted for a new one.
        if (cmd_valid_q && !sdr_cmd_ready) begin
          cmd_valid_d = 1'b1;
        end else if (rem_after == '0) begin
          cmd_valid_d = 1'b0;
          cmd_addr_d  = '0;
          cmd_len_d   = '0;
          state_d     = DRAIN;
        end else if (credit_ok) begin
          cmd_valid_d = 1'b1;
          cmd_addr_d  = addr_after;
          cmd_len_d   = query_len;
        end else begin
          cmd_valid_d = 1'b0;
          cmd_addr_d  = '0;
          cmd_len_d   = '0;
        end
      end
      DRAIN: begin
        if (drain_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (sdr_rd_valid && ((inflight == '0) || fifo_wrfull)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      wrreq_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wrreq_q     <= wrreq_d;
      data_q      <= data_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign sdr_cmd_valid = cmd_valid_q;
  assign sdr_cmd_addr  = cmd_addr_q;
  assign sdr_cmd_len   = cmd_len_q;
  assign fifo_wrreq    = wrreq_q;
  assign fifo_data     = data_q;

endmodule

// File: tb/tb_sdram_read_burst.sv
// Directed self-checking bench for sdram_read_burst with a simple SDRAM return model.
module tb_sdram_read_burst;

  localparam int ADDR_W = 25;
  localparam int LEN_W  = 16;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                due;
  } word_t;

  logic              clk = 1'b0;
  logic              aclr = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LEN_W-1:0]  req_len = '0;
  logic              busy, done, err;
  logic              sdr_cmd_valid;
  logic              sdr_cmd_ready = 1'b1;
  logic [ADDR_W-1:0] sdr_cmd_addr;
  logic [4:0]        sdr_cmd_len;
  logic              sdr_rd_valid;
  logic [15:0]       sdr_rd_data;
  logic              fifo_wrreq;
  logic [15:0]       fifo_data;
  logic [5:0]        fifo_wrusedw = '0;
  logic              fifo_wrfull = 1'b0;

  logic              model_en = 1'b1;
  logic              model_rd_valid = 1'b0;
  logic [15:0]       model_rd_data = '0;
  logic              man_rd_valid = 1'b0;
  logic [15:0]       man_rd_data = '0;

  int                cyc = 0;
  int                n_cmp = 0;
  int                n_err = 0;
  logic [29:0]       cmd_log[$];
  logic [15:0]       wr_log[$];
  word_t             pend[$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                last_rd_cyc = 0;

  assign sdr_rd_valid = model_en ? model_rd_valid : man_rd_valid;
  assign sdr_rd_data  = model_en ? model_rd_data : man_rd_data;

  sdram_read_burst dut (
    .clk          (clk),
    .aclr         (aclr),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_len      (req_len),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .sdr_cmd_valid(sdr_cmd_valid),
    .sdr_cmd_ready(sdr_cmd_ready),
    .sdr_cmd_addr (sdr_cmd_addr),
    .sdr_cmd_len  (sdr_cmd_len),
    .sdr_rd_valid (sdr_rd_valid),
    .sdr_rd_data  (sdr_rd_data),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_data    (fifo_data),
    .fifo_wrusedw (fifo_wrusedw),
    .fifo_wrfull  (fifo_wrfull)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SDRAM model: logs traffic mid-cycle and returns each burst's words in order, 3 cycles after its command.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (!aclr && sdr_cmd_valid && sdr_cmd_ready) begin
        cmd_log.push_back({sdr_cmd_addr, sdr_cmd_len});
        if (model_en) begin
          for (int i = 0; i < int'(sdr_cmd_len); i++) begin
            pend.push_back('{addr: sdr_cmd_addr + ADDR_W'(i), due: cyc + 3});
          end
        end
      end
      if (fifo_wrreq) wr_log.push_back(fifo_data);
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (sdr_rd_valid) last_rd_cyc = cyc;
      @(posedge clk);
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        w = pend.pop_front();
        model_rd_valid = 1'b1;
        model_rd_data  = 16'(w.addr) ^ 16'hC3C3;
      end else begin
        model_rd_valid = 1'b0;
      end
    end
  end

  task automatic send_req(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cmd_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sdr_cmd_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, busy, done, err, sdr_cmd_valid, fifo_wrreq} !== 6'b100000) begin
      n_err++;
      $display("[TB] FAIL reset_flags: got %b want 100000", {req_ready, busy, done, err, sdr_cmd_valid, fifo_wrreq});
    end
    n_cmp++;
    if ({sdr_cmd_addr, sdr_cmd_len, fifo_data} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_buses: addr %h len %0d data %h want all zero", sdr_cmd_addr, sdr_cmd_len, fifo_data);
    end
    aclr = 1'b0;
  endtask

  task automatic test_basic_read();
    logic [29:0] exp_cmd[3];
    logic [29:0] got_cmd;
    logic [15:0] got_w, exp_w;
    int          cbase, wbase, dbase;
    bit          seen;
    exp_cmd[0] = {25'h100, 5'd8};
    exp_cmd[1] = {25'h108, 5'd8};
    exp_cmd[2] = {25'h110, 5'd4};
    model_en = 1'b1;
    sdr_cmd_ready = 1'b1;
    cbase = cmd_log.size();
    wbase = wr_log.size();
    dbase = done_cnt;
    send_req(25'h100, 16'd20);
    n_cmp++;
    if ({busy, req_ready, sdr_cmd_valid} !== 3'b100) begin
      n_err++;
      $display("[TB] FAIL basic_cycle1: busy/ready/valid %b want 100", {busy, req_ready, sdr_cmd_valid});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (sdr_cmd_valid !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL basic_cycle2_valid: got %b want 1", sdr_cmd_valid);
    end
    wait_done(200, seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("[TB] FAIL basic_done_timeout: done not seen within 200 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (cmd_log.size() - cbase != 3) begin
      n_err++;
      $display("[TB] FAIL basic_cmd_count: got %0d want 3", cmd_log.size() - cbase);
    end
    for (int i = 0; i < 3; i++) begin
      got_cmd = (cbase + i < cmd_log.size()) ? cmd_log[cbase + i] : 'x;
      n_cmp++;
      if (got_cmd !== exp_cmd[i]) begin
        n_err++;
        $display("[TB] FAIL basic_cmd%0d: got addr %h len %0d want addr %h len %0d",
                 i, got_cmd[29:5], got_cmd[4:0], exp_cmd[i][29:5], exp_cmd[i][4:0]);
      end
    end
    n_cmp++;
    if (wr_log.size() - wbase != 20) begin
      n_err++;
      $display("[TB] FAIL basic_wr_count: got %0d want 20", wr_log.size() - wbase);
    end
    for (int i = 0; i < 20; i++) begin
      got_w = (wbase + i < wr_log.size()) ? wr_log[wbase + i] : 'x;
      exp_w = (16'h0100 + 16'(i)) ^ 16'hC3C3;
      n_cmp++;
      if (got_w !== exp_w) begin
        n_err++;
        $display("[TB] FAIL basic_data%0d: got %h want %h", i, got_w, exp_w);
      end
    end
    n_cmp++;
    if (done_cnt - dbase != 1) begin
      n_err++;
      $display("[TB] FAIL basic_done_pulses: got %0d want 1", done_cnt - dbase);
    end
    n_cmp++;
    if (done_cyc - last_rd_cyc != 2) begin
      n_err++;
      $display("[TB] FAIL basic_done_latency: got %0d want 2", done_cyc - last_rd_cyc);
    end
    n_cmp++;
    if ({err, busy, req_ready} !== 3'b001) begin
      n_err++;
      $display("[TB] FAIL basic_end_state: err/busy/ready %b want 001", {err, busy, req_ready});
    end
  endtask

  task automatic test_backpressure();
    bit seen_valid;
    bit seen;
    int cbase;
    model_en = 1'b1;
    sdr_cmd_ready = 1'b1;
    fifo_wrusedw = 6'd54;
    cbase = cmd_log.size();
    send_req(25'h2000, 16'd8);
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (sdr_cmd_valid) seen_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (seen_valid || cmd_log.size() != cbase) begin
      n_err++;
      $display("[TB] FAIL bp_blocked: command issued with usedw 54 (valid seen %b, cmds %0d) want none",
               seen_valid, cmd_log.size() - cbase);
    end
    fifo_wrusedw = 6'd52;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({sdr_cmd_valid, sdr_cmd_addr, sdr_cmd_len} !== {1'b1, 25'h2000, 5'd8}) begin
      n_err++;
      $display("[TB] FAIL bp_release: valid %b addr %h len %0d want 1 2000 8", sdr_cmd_valid, sdr_cmd_addr, sdr_cmd_len);
    end
    wait_done(100, seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("[TB] FAIL bp_done_timeout: done not seen within 100 cycles");
    end
    fifo_wrusedw = 6'd0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_cmd_hold();
    bit seen;
    int cbase;
    model_en = 1'b1;
    sdr_cmd_ready = 1'b0;
    cbase = cmd_log.size();
    send_req(25'h3000, 16'd4);
    wait_cmd_valid(10, seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("[TB] FAIL hold_valid_timeout: sdr_cmd_valid not seen within 10 cycles");
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({sdr_cmd_valid, sdr_cmd_addr, sdr_cmd_len} !== {1'b1, 25'h3000, 5'd4}) begin
        n_err++;
        $display("[TB] FAIL hold_cycle%0d: valid %b addr %h len %0d want 1 3000 4", i, sdr_cmd_valid, sdr_cmd_addr, sdr_cmd_len);
      end
    end
    sdr_cmd_ready = 1'b1;
    wait_done(100, seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("[TB] FAIL hold_done_timeout: done not seen within 100 cycles");
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (cmd_log.size() - cbase != 1) begin
      n_err++;
      $display("[TB] FAIL hold_cmd_count: got %0d want 1", cmd_log.size() - cbase);
    end
  endtask

  task automatic test_simul_handshake();
    bit seen;
    int wbase;
    model_en = 1'b0;
    sdr_cmd_ready = 1'b1;
    wbase = wr_log.size();
    send_req(25'h4000, 16'd16);
    wait_cmd_valid(10, seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("[TB] FAIL simul_valid_timeout: sdr_cmd_valid not seen within 10 cycles");
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({dut.u_credit.inflight_q, sdr_cmd_valid, sdr_cmd_addr} !== {7'd8, 1'b1, 25'h4008}) begin
      n_err++;
      $display("[TB] FAIL simul_pre: inflight %0d valid %b addr %h want 8 1 4008",
               dut.u_credit.inflight_q, sdr_cmd_valid, sdr_cmd_addr);
    end
    man_rd_valid = 1'b1;
    man_rd_data  = 16'h4000;
    @(posedge clk);
    #1;
    n_cmp++;
    if (dut.u_credit.inflight_q !== 7'd15) begin
      n_err++;
      $display("[TB] FAIL simul_inflight: got %0d want 15", dut.u_credit.inflight_q);
    end
    for (int i = 1; i < 16; i++) begin
      man_rd_data = 16'h4000 + 16'(i);
      @(posedge clk);
      #1;
    end
    man_rd_valid = 1'b0;
    wait_done(20, seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("[TB] FAIL simul_done_timeout: done not seen within 20 cycles");
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (wr_log.size() - wbase != 16 || err !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL simul_words: got %0d words err %b want 16 words err 0", wr_log.size() - wbase, err);
    end
    model_en = 1'b1;
  endtask

  task automatic test_zero_len();
    int cbase;
    cbase = cmd_log.size();
    send_req(25'h5000, 16'd0);
    n_cmp++;
    if ({busy, req_ready, done} !== 3'b100) begin
      n_err++;
      $display("[TB] FAIL zero_cycle1: busy/ready/done %b want 100", {busy, req_ready, done});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({done, sdr_cmd_valid} !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL zero_cycle2: done/valid %b want 10", {done, sdr_cmd_valid});
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({done, req_ready, busy} !== 3'b010 || cmd_log.size() != cbase) begin
      n_err++;
      $display("[TB] FAIL zero_cycle3: done/ready/busy %b cmds %0d want 010 and 0 cmds",
               {done, req_ready, busy}, cmd_log.size() - cbase);
    end
  endtask

  task automatic test_errors();
    model_en = 1'b0;
    @(posedge clk);
    #1;
    man_rd_valid = 1'b1;
    man_rd_data  = 16'hBEEF;
    @(posedge clk);
    #1;
    man_rd_valid = 1'b0;
    n_cmp++;
    if ({err, fifo_wrreq, fifo_data} !== {1'b1, 1'b1, 16'hBEEF}) begin
      n_err++;
      $display("[TB] FAIL err_stale: err %b wrreq %b data %h want 1 1 beef", err, fifo_wrreq, fifo_data);
    end
    n_cmp++;
    if (dut.u_credit.inflight_q !== 7'd0) begin
      n_err++;
      $display("[TB] FAIL err_inflight: got %0d want 0", dut.u_credit.inflight_q);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL err_sticky: got %b want 1", err);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    model_en = 1'b0;
    sdr_cmd_ready = 1'b0;
    send_req(25'h6000, 16'd32);
    wait_cmd_valid(10, seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("[TB] FAIL rst_valid_timeout: sdr_cmd_valid not seen within 10 cycles");
    end
    #3;
    aclr = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, busy, done, err, sdr_cmd_valid, fifo_wrreq} !== 6'b100000 ||
        {sdr_cmd_addr, sdr_cmd_len, fifo_data} !== '0) begin
      n_err++;
      $display("[TB] FAIL rst_mid: flags %b addr %h len %0d data %h want 100000 and zero buses",
               {req_ready, busy, done, err, sdr_cmd_valid, fifo_wrreq}, sdr_cmd_addr, sdr_cmd_len, fifo_data);
    end
    @(posedge clk);
    #1;
    aclr = 1'b0;
    sdr_cmd_ready = 1'b1;
    man_rd_valid = 1'b1;
    man_rd_data  = 16'h5A5A;
    @(posedge clk);
    #1;
    man_rd_valid = 1'b0;
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL rst_stale_err: got %b want 1", err);
    end
    send_req(25'h7000, 16'd0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL rst_err_clear: got %b want 0", err);
    end
    wait_done(5, seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("[TB] FAIL rst_done_timeout: done not seen within 5 cycles");
    end
    model_en = 1'b1;
  endtask

  initial begin
    $display("[TB] starting sdram_read_burst bench");
    test_reset();
    test_basic_read();
    test_backpressure();
    test_cmd_hold();
    test_simul_handshake();
    test_zero_len();
    test_errors();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
